// File: rtl/axi4_lite_csr_pkg.sv
// Shared definitions for the AXI4-Lite CSR bank.
//  - Data/strobe widths and AXI response codes.
//  - Write FSM state encoding.
//  - Byte-masked merge and address-decode helpers used by the bank and its write FSM.
package axi4_lite_csr_pkg;

  localparam int unsigned CSR_DATA_W = 32;
  localparam int unsigned CSR_STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    RESP
  } wr_state_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [CSR_DATA_W-1:0] csr_strb_merge(
    input logic [CSR_DATA_W-1:0] cur,
    input logic [CSR_DATA_W-1:0] wdat,
    input logic [CSR_STRB_W-1:0] strb
  );
    logic [CSR_DATA_W-1:0] res;
    res = cur;
    for (int unsigned b = 0; b < CSR_STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

  // Word-aligned and inside [base, base + 4*cnt).
  function automatic logic csr_addr_hit(
    input logic [31:0]  addr,
    input logic [31:0]  base,
    input int unsigned  cnt
  );
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < (cnt << 2));
  endfunction

  function automatic logic [31:0] csr_addr_idx(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/axi4_lite_csr_wr_fsm.sv
// AXI4-Lite write channel handler for the CSR bank.
// Captures AW and W independently (same cycle or either order), runs the
// IDLE/HAVE_AW/HAVE_W/RESP state machine and drives the B channel.
// Ports:
//  clk_i, rst_n_i           clock, synchronous active-low reset
//  awaddr/awvalid/awready   write address channel
//  wdata/wstrb/wvalid/wready write data channel
//  bresp/bvalid/bready      write response channel
//  apply                    high in the cycle the write takes effect (last handshake)
//  hit, idx, data, strb     decoded target and payload of the write, valid with apply
module axi4_lite_csr_wr_fsm #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned REG_CNT   = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        apply,
  output logic        hit,
  output logic [31:0] idx,
  output logic [31:0] data,
  output logic [3:0]  strb
);
  import axi4_lite_csr_pkg::*;

  wr_state_t   state_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        aw_hs;
  logic        w_hs;
  logic [31:0] eff_addr;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // The write completes in the cycle of the last handshake, so the payload is
  // taken from the captured copy for the channel that arrived first and from
  // the bus for the one arriving now.
  always_comb begin
    eff_addr = (state_q == HAVE_AW) ? addr_q : awaddr;
    data     = (state_q == HAVE_W)  ? data_q : wdata;
    strb     = (state_q == HAVE_W)  ? strb_q : wstrb;
    apply    = ((state_q == IDLE)    && aw_hs && w_hs) ||
               ((state_q == HAVE_AW) && w_hs) ||
               ((state_q == HAVE_W)  && aw_hs);
    hit      = csr_addr_hit(eff_addr, BASE_ADDR, REG_CNT);
    idx      = csr_addr_idx(eff_addr, BASE_ADDR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs && w_hs) begin
            state_q <= RESP;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= hit ? RESP_OKAY : RESP_SLVERR;
          end else if (aw_hs) begin
            state_q <= HAVE_AW;
            addr_q  <= awaddr;
            awready <= 1'b0;
          end else if (w_hs) begin
            state_q <= HAVE_W;
            data_q  <= wdata;
            strb_q  <= wstrb;
            wready  <= 1'b0;
          end
        end
        HAVE_AW: begin
          if (w_hs) begin
            state_q <= RESP;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= hit ? RESP_OKAY : RESP_SLVERR;
          end
        end
        HAVE_W: begin
          if (aw_hs) begin
            state_q <= RESP;
            awready <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= hit ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RESP: begin
          if (bready) begin
            state_q <= IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
          end
        end
        default: begin
          state_q <= IDLE;
          awready <= 1'b1;
          wready  <= 1'b1;
          bvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_csr_bank.sv
// Generic AXI4-Lite control/status register bank.
// REG_CNT 32-bit registers; RO_MASK bit k selects status (read from sr_i)
// instead of control (stored, driven on cr_o). Out-of-range or misaligned
// accesses return SLVERR.
// Optional macro CSR_SHADOW_EN: writes land in a shadow bank that is copied
// to cr_o on the cycle after frame_start_i; readback returns the shadow.
// Ports (the csr_* group is the flattened AXI4-Lite slave bundle):
//  clk_i, rst_n_i        clock, synchronous active-low reset
//  csr_aw*, csr_w*, csr_b*  write address / data / response channels
//  csr_ar*, csr_r*       read address / data channels
//  cr_o                  active control values, slice k = register k
//  sr_i                  status inputs, used where RO_MASK[k] = 1
//  cr_wr_stb_o           one-cycle pulse per register accepting a write
//  frame_start_i         frame-boundary pulse (shadow commit)
module axi4_lite_csr_bank #(
  parameter logic [31:0]         BASE_ADDR = 32'h0000_0000,
  parameter int unsigned         REG_CNT   = 8,
  parameter logic [REG_CNT-1:0]  RO_MASK   = '0,
  parameter logic [REG_CNT*32-1:0] RST_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [31:0]           csr_awaddr,
  input  logic                  csr_awvalid,
  output logic                  csr_awready,
  input  logic [31:0]           csr_wdata,
  input  logic [3:0]            csr_wstrb,
  input  logic                  csr_wvalid,
  output logic                  csr_wready,
  output logic [1:0]            csr_bresp,
  output logic                  csr_bvalid,
  input  logic                  csr_bready,
  input  logic [31:0]           csr_araddr,
  input  logic                  csr_arvalid,
  output logic                  csr_arready,
  output logic [31:0]           csr_rdata,
  output logic [1:0]            csr_rresp,
  output logic                  csr_rvalid,
  input  logic                  csr_rready,
  output logic [REG_CNT*32-1:0] cr_o,
  input  logic [REG_CNT*32-1:0] sr_i,
  output logic [REG_CNT-1:0]    cr_wr_stb_o,
  input  logic                  frame_start_i
);
  import axi4_lite_csr_pkg::*;

  logic                  wr_apply;
  logic                  wr_hit;
  logic [31:0]           wr_idx;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [REG_CNT-1:0]    wr_sel;
  logic [REG_CNT*32-1:0] cr_q;
  logic [REG_CNT*32-1:0] rd_bank;
  logic                  rd_hit;
  logic [31:0]           rd_idx;
  logic [31:0]           rd_word;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic                  unused_inputs;

  assign unused_inputs = ^{frame_start_i, sr_i};

  axi4_lite_csr_wr_fsm #(
    .BASE_ADDR (BASE_ADDR),
    .REG_CNT   (REG_CNT)
  ) u_wr_fsm (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .awaddr  (csr_awaddr),
    .awvalid (csr_awvalid),
    .awready (csr_awready),
    .wdata   (csr_wdata),
    .wstrb   (csr_wstrb),
    .wvalid  (csr_wvalid),
    .wready  (csr_wready),
    .bresp   (csr_bresp),
    .bvalid  (csr_bvalid),
    .bready  (csr_bready),
    .apply   (wr_apply),
    .hit     (wr_hit),
    .idx     (wr_idx),
    .data    (wr_data),
    .strb    (wr_strb)
  );

  // Status registers swallow writes silently: OKAY response, no strobe.
  always_comb begin
    wr_sel = '0;
    for (int unsigned k = 0; k < REG_CNT; k++) begin
      if (wr_apply && wr_hit && (wr_idx == k) && !RO_MASK[k]) wr_sel[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cr_wr_stb_o <= '0;
    else          cr_wr_stb_o <= wr_sel;
  end

`ifdef CSR_SHADOW_EN
  logic [REG_CNT*32-1:0] shadow_q;

  // The commit samples shadow_q before this edge's write lands, so a write
  // coinciding with frame_start_i waits for the following frame.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q <= RST_VAL;
      cr_q     <= RST_VAL;
    end else begin
      for (int unsigned k = 0; k < REG_CNT; k++) begin
        if (wr_sel[k]) shadow_q[32*k +: 32] <= csr_strb_merge(shadow_q[32*k +: 32], wr_data, wr_strb);
      end
      if (frame_start_i) cr_q <= shadow_q;
    end
  end

  assign rd_bank = shadow_q;
`else
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cr_q <= RST_VAL;
    end else begin
      for (int unsigned k = 0; k < REG_CNT; k++) begin
        if (wr_sel[k]) cr_q[32*k +: 32] <= csr_strb_merge(cr_q[32*k +: 32], wr_data, wr_strb);
      end
    end
  end

  assign rd_bank = cr_q;
`endif

  assign cr_o = cr_q;

  // Read path: single outstanding read, data registered at the AR handshake.
  always_comb begin
    rd_hit  = csr_addr_hit(csr_araddr, BASE_ADDR, REG_CNT);
    rd_idx  = csr_addr_idx(csr_araddr, BASE_ADDR);
    rd_word = '0;
    for (int unsigned k = 0; k < REG_CNT; k++) begin
      if (rd_hit && (rd_idx == k)) rd_word = RO_MASK[k] ? sr_i[32*k +: 32] : rd_bank[32*k +: 32];
    end
  end

  assign csr_arready = !rvalid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (csr_arvalid && !rvalid_q) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && csr_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign csr_rvalid = rvalid_q;
  assign csr_rdata  = rdata_q;
  assign csr_rresp  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_csr_bank.sv
// Directed self-checking bench for axi4_lite_csr_bank
// (REG_CNT=4, RO_MASK=4'b1000, BASE_ADDR=32'h100). Honours CSR_SHADOW_EN.
module tb_axi4_lite_csr_bank;

  localparam logic [127:0] RST_V = {32'h0000_0000, 32'hCAFE_0002, 32'h1111_2222, 32'h0000_00A0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] cr;
  logic [127:0] sr;
  logic [3:0]   stb;
  logic         fs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned stb_cnt[4];
  int unsigned stb_total = 0;

  always #5 clk = ~clk;

  axi4_lite_csr_bank #(
    .BASE_ADDR (32'h100),
    .REG_CNT   (4),
    .RO_MASK   (4'b1000),
    .RST_VAL   (RST_V)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .csr_awaddr    (awaddr),
    .csr_awvalid   (awvalid),
    .csr_awready   (awready),
    .csr_wdata     (wdata),
    .csr_wstrb     (wstrb),
    .csr_wvalid    (wvalid),
    .csr_wready    (wready),
    .csr_bresp     (bresp),
    .csr_bvalid    (bvalid),
    .csr_bready    (bready),
    .csr_araddr    (araddr),
    .csr_arvalid   (arvalid),
    .csr_arready   (arready),
    .csr_rdata     (rdata),
    .csr_rresp     (rresp),
    .csr_rvalid    (rvalid),
    .csr_rready    (rready),
    .cr_o          (cr),
    .sr_i          (sr),
    .cr_wr_stb_o   (stb),
    .frame_start_i (fs)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (stb[k] === 1'b1) begin
        stb_cnt[k]++;
        stb_total++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // AW presented from cycle aw_dly, W from cycle w_dly; bready held low for
  // b_dly cycles once bvalid is up. fs_hs raises frame_start_i in the cycle
  // of the completing handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int unsigned aw_dly, input int unsigned w_dly, input int unsigned b_dly,
                           input bit fs_hs, output logic [1:0] resp, output int unsigned lat);
    int unsigned c;
    bit aw_done;
    bit w_done;
    c = 0; aw_done = 0; w_done = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && c < 50) begin
      @(negedge clk);
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      fs = fs_hs && aw_done && w_done;
      c++;
    end
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    @(negedge clk);
    awvalid = 0; wvalid = 0; fs = 0;
    lat = 1;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int unsigned i = 0; i < b_dly; i++) begin
      check("b_hold", {awready, wready, bvalid}, 3'b001);
      @(negedge clk);
    end
    resp = bresp;
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("b_drop", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int unsigned r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int unsigned c;
    c = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1;
    while (!arready && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    arvalid = 0;
    check("r_valid", rvalid, 1'b1);
    data = rdata; resp = rresp;
    for (int unsigned i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check("r_hold", {rvalid, rresp, rdata}, {1'b1, resp, data});
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("r_drop", rvalid, 1'b0);
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    fs = 1;
    @(negedge clk);
    fs = 0;
  endtask

  initial begin
    logic [1:0]   resp;
    logic [1:0]   rr;
    logic [31:0]  rd;
    logic [127:0] rv;
    int unsigned  lat;
    int unsigned  s_tot;
    int unsigned  s1;
    rv = RST_V;
    rst_n = 0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; fs = 0;
    sr = {32'h5A5A_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
    repeat (3) @(negedge clk);
    rst_n = 1;

    // 1: reset state and readback of reset values
    check("rst_ready", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    check("rst_stb", stb, 4'b0000);
    check("rst_rdata", {rdata, bresp, rresp}, 36'h0);
    check("rst_cr", cr[95:0], RST_V[95:0]);
    for (int k = 0; k < 3; k++) begin
      axi_read(32'h100 + 32'(4*k), 0, rd, rr);
      check("t1_rd", {rr, rd}, {2'b00, rv[32*k +: 32]});
    end
    axi_read(32'h10C, 0, rd, rr);
    check("t1_rd_sr", {rr, rd}, {2'b00, 32'h5A5A_0003});

    // 2: AW then W three cycles later, partial strobe
    s1 = stb_cnt[1]; s_tot = stb_total;
    axi_write(32'h104, 32'hA5A5_1234, 4'b0011, 0, 3, 0, 0, resp, lat);
    check("t2_bresp", resp, 2'b00);
    check("t2_blat", lat, 1);
    check("t2_stb1", stb_cnt[1] - s1, 1);
    check("t2_stb_tot", stb_total - s_tot, 1);
    axi_read(32'h104, 0, rd, rr);
    check("t2_rd", {rr, rd}, {2'b00, 32'h1111_1234});
    frame_pulse();
    check("t2_cr", cr[63:32], 32'h1111_1234);

    // 3: W before AW, bready withheld
    s_tot = stb_total;
    axi_write(32'h108, 32'h0BAD_F00D, 4'b1111, 2, 0, 5, 0, resp, lat);
    check("t3_bresp", resp, 2'b00);
    check("t3_blat", lat, 1);
    check("t3_stb_tot", stb_total - s_tot, 1);
    frame_pulse();
    check("t3_cr", cr[95:64], 32'h0BAD_F00D);

    // 4: out-of-range and misaligned accesses
    s_tot = stb_total;
    axi_write(32'h110, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 0, resp, lat);
    check("t4_bresp_oor", resp, 2'b10);
    axi_write(32'h102, 32'hFFFF_FFFF, 4'b1111, 1, 0, 0, 0, resp, lat);
    check("t4_bresp_mis", resp, 2'b10);
    check("t4_stb_tot", stb_total - s_tot, 0);
    frame_pulse();
    check("t4_cr", cr[95:0], {32'h0BAD_F00D, 32'h1111_1234, 32'h0000_00A0});
    axi_read(32'h200, 3, rd, rr);
    check("t4_rd_oor", {rr, rd}, {2'b10, 32'h0});
    axi_read(32'h0FC, 0, rd, rr);
    check("t4_rd_below", {rr, rd}, {2'b10, 32'h0});

    // 5: write to the status register
    s_tot = stb_total;
    axi_write(32'h10C, 32'h1234_0000, 4'b1111, 0, 0, 0, 0, resp, lat);
    check("t5_bresp", resp, 2'b00);
    check("t5_stb_tot", stb_total - s_tot, 0);
    axi_read(32'h10C, 0, rd, rr);
    check("t5_rd", {rr, rd}, {2'b00, 32'h5A5A_0003});
    sr[127:96] = 32'h600D_CAFE;
    axi_read(32'h10C, 0, rd, rr);
    check("t5_rd_new", {rr, rd}, {2'b00, 32'h600D_CAFE});

    // 6: write reg0 coinciding with frame_start_i
    axi_write(32'h100, 32'h0000_0007, 4'b1111, 0, 0, 0, 1, resp, lat);
    check("t6_bresp", resp, 2'b00);
`ifdef CSR_SHADOW_EN
    check("t6_cr_old", cr[31:0], 32'h0000_00A0);
`else
    check("t6_cr_new", cr[31:0], 32'h0000_0007);
`endif
    axi_read(32'h100, 0, rd, rr);
    check("t6_rd", {rr, rd}, {2'b00, 32'h0000_0007});
    frame_pulse();
    check("t6_cr_commit", cr[31:0], 32'h0000_0007);

    // 7: reset with AW captured but W never sent
    s_tot = stb_total;
    @(negedge clk);
    awaddr = 32'h104; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    check("t7_aw_busy", awready, 1'b0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("t7_ready", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    repeat (3) @(negedge clk);
    check("t7_no_b", bvalid, 1'b0);
    check("t7_cr", cr[95:0], RST_V[95:0]);
    check("t7_stb_tot", stb_total - s_tot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
